// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
// IF_ID packs {fetched PC, instruction}: instruction in the low bits, PC above it.
package fetch_pkg;

   localparam int DEF_PC_W    = 32;
   localparam int DEF_INSTR_W = 32;
   localparam int DEF_DEPTH   = 128;

   localparam logic [DEF_INSTR_W-1:0] DEF_NOP_INSTR = '0;

   localparam int INSTR_LSB = 0;

   // The PC field starts right above the instruction field.
   function automatic int pc_lsb(input int instr_w);
      return instr_w;
   endfunction

   typedef enum logic [1:0] {
      ACT_RESET,
      ACT_REDIRECT,
      ACT_HOLD,
      ACT_FETCH
   } fetch_act_e;

   // Per-edge priority: reset > redirect > stall > normal fetch.
   function automatic fetch_act_e pick_action(input logic reset_n,
                                              input logic redirect,
                                              input logic stall);
      if (!reset_n)     return ACT_RESET;
      else if (redirect) return ACT_REDIRECT;
      else if (stall)    return ACT_HOLD;
      else               return ACT_FETCH;
   endfunction

endpackage

// File: rtl/fetch_imem.sv
// Word-addressed instruction memory: synchronous write port, combinational
// read port, and a range flag telling the caller whether raddr maps to a word.
module fetch_imem
   import fetch_pkg::*;
#(
   parameter int                 PC_W      = DEF_PC_W,
   parameter int                 INSTR_W   = DEF_INSTR_W,
   parameter int                 DEPTH     = DEF_DEPTH,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEF_NOP_INSTR),
   localparam int                AW        = $clog2(DEPTH)
) (
   input  logic               clock,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [PC_W-1:0]    raddr,
   output logic [INSTR_W-1:0] rdata,
   output logic               in_range
);

   logic [INSTR_W-1:0] mem_q [DEPTH];
   logic               wr_ok;

   // A power-of-two depth covers every write address, so no guard is needed.
   if (DEPTH == (1 << AW)) begin : g_pow2
      assign wr_ok = 1'b1;
   end else begin : g_npow2
      assign wr_ok = (32'(waddr) < 32'(DEPTH));
   end

   // NOTE: the array has no reset; clearing it would need a write per word,
   // and program loading overwrites whatever it holds anyway.
   always_ff @(posedge clock) begin
      if (we && wr_ok) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign in_range = (64'(raddr) < 64'(DEPTH));

   // The read sees the pre-edge contents, so a same-cycle write of the
   // fetched address returns the old word.
   assign rdata = in_range ? mem_q[AW'(raddr)] : NOP_INSTR;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, instruction memory and the IF/ID
// register, with stall, redirect bubble and sticky out-of-range fault.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int                 PC_W      = DEF_PC_W,
   parameter int                 INSTR_W   = DEF_INSTR_W,
   parameter int                 DEPTH     = DEF_DEPTH,
   parameter int                 RESET_PC  = 0,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEF_NOP_INSTR)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       stall,
   input  logic                       redirect_valid,
   input  logic [PC_W-1:0]            redirect_pc,
   input  logic                       imem_we,
   input  logic [$clog2(DEPTH)-1:0]   imem_waddr,
   input  logic [INSTR_W-1:0]         imem_wdata,
   output logic [PC_W-1:0]            pc,
   output logic [PC_W+INSTR_W-1:0]    IF_ID,
   output logic                       if_id_valid,
   output logic                       fetch_fault
);

   localparam int PC_LSB = pc_lsb(INSTR_W);

   logic [PC_W-1:0]         pc_q, pc_d;
   logic [PC_W+INSTR_W-1:0] if_id_q, if_id_d;
   logic                    valid_q, valid_d;
   logic                    fault_q, fault_d;

   logic [INSTR_W-1:0]      fetch_word;
   logic                    fetch_in_range;
   fetch_act_e              act;

   fetch_imem #(
      .PC_W      (PC_W),
      .INSTR_W   (INSTR_W),
      .DEPTH     (DEPTH),
      .NOP_INSTR (NOP_INSTR)
   ) u_imem (
      .clock    (clock),
      .we       (imem_we),
      .waddr    (imem_waddr),
      .wdata    (imem_wdata),
      .raddr    (pc_q),
      .rdata    (fetch_word),
      .in_range (fetch_in_range)
   );

   // NOTE: every next-state variable gets its hold value first, so no path
   // through the case below can leave one unassigned and infer a latch.
   always_comb begin
      act     = pick_action(reset, redirect_valid, stall);
      pc_d    = pc_q;
      if_id_d = if_id_q;
      valid_d = valid_q;
      fault_d = fault_q;
      unique case (act)
         ACT_RESET: begin
            pc_d    = PC_W'(RESET_PC);
            if_id_d = '0;
            valid_d = 1'b0;
            fault_d = 1'b0;
         end
         // The IF_ID data field is left as-is; valid=0 marks the bubble.
         ACT_REDIRECT: begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
         end
         ACT_HOLD: begin
         end
         ACT_FETCH: begin
            if_id_d[PC_LSB    +: PC_W]    = pc_q;
            if_id_d[INSTR_LSB +: INSTR_W] = fetch_word;
            valid_d = 1'b1;
            pc_d    = pc_q + PC_W'(1);
            if (!fetch_in_range) begin
               fault_d = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
   end

   assign pc          = pc_q;
   assign IF_ID       = if_id_q;
   assign if_id_valid = valid_q;
   assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a reference model pushes the expected
// post-edge state into a scoreboard queue, popped and compared after each edge.
module tb_fetch_stage;

   localparam int          PC_W    = 32;
   localparam int          INSTR_W = 32;
   localparam int          DEPTH   = 128;
   localparam int          RST_PC  = 0;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [63:0] if_id;
      logic        valid;
      logic        fault;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_we = 1'b0;
   logic [6:0]  imem_waddr = '0;
   logic [31:0] imem_wdata = '0;
   logic [31:0] pc;
   logic [63:0] IF_ID;
   logic        if_id_valid;
   logic        fetch_fault;

   int vectors     = 0;
   int miscompares = 0;

   exp_t sb[$];

   // Reference model state.
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_pc    = '0;
   logic [63:0] m_if_id = '0;
   logic        m_valid = 1'b0;
   logic        m_fault = 1'b0;

   fetch_stage #(
      .PC_W      (PC_W),
      .INSTR_W   (INSTR_W),
      .DEPTH     (DEPTH),
      .RESET_PC  (RST_PC),
      .NOP_INSTR (NOP)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_we        (imem_we),
      .imem_waddr     (imem_waddr),
      .imem_wdata     (imem_wdata),
      .pc             (pc),
      .IF_ID          (IF_ID),
      .if_id_valid    (if_id_valid),
      .fetch_fault    (fetch_fault)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Drive one cycle of inputs, predict the post-edge state, advance, compare.
   task automatic step(input logic rst_n, input logic st, input logic rv,
                       input logic [31:0] rpc, input logic we,
                       input logic [6:0] wa, input logic [31:0] wd,
                       input string tag);
      exp_t        e;
      exp_t        got;
      logic [31:0] word;
      reset          = rst_n;
      stall          = st;
      redirect_valid = rv;
      redirect_pc    = rpc;
      imem_we        = we;
      imem_waddr     = wa;
      imem_wdata     = wd;

      if (!rst_n) begin
         m_pc = 32'(RST_PC); m_if_id = '0; m_valid = 1'b0; m_fault = 1'b0;
      end else if (rv) begin
         m_pc = rpc; m_valid = 1'b0;
      end else if (!st) begin
         word    = (m_pc < 32'(DEPTH)) ? m_mem[m_pc[6:0]] : NOP;
         m_if_id = {m_pc, word};
         m_valid = 1'b1;
         if (m_pc >= 32'(DEPTH)) m_fault = 1'b1;
         m_pc    = m_pc + 32'd1;
      end
      if (we) m_mem[wa] = wd;
      e.pc = m_pc; e.if_id = m_if_id; e.valid = m_valid; e.fault = m_fault;
      sb.push_back(e);

      @(posedge clock);
      #1;
      got = sb.pop_front();
      check({tag, ".pc"},    64'(pc),          64'(got.pc));
      check({tag, ".if_id"}, IF_ID,            got.if_id);
      check({tag, ".valid"}, 64'(if_id_valid), 64'(got.valid));
      check({tag, ".fault"}, 64'(fetch_fault), 64'(got.fault));
   endtask

   task automatic run(input string tag);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0, tag);
   endtask

   initial begin
      @(negedge clock);

      // Program load while reset is held.
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 1'b0, 1'b0, '0, 1'b1, 7'(i),
              (i < 8) ? 32'(i + 'h100) : 32'(32'h5000 + i), "load");
      end
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, 7'h20, 32'hDEAD, "load20");
      check("rst_pc", 64'(pc), 64'(RST_PC));
      check("rst_ifid", IF_ID, 64'h0);
      check("rst_valid", 64'(if_id_valid), 64'd0);

      // Sequential fetch after release.
      run("seq0");
      check("tp1_first", IF_ID, {32'h0, 32'h100});
      check("tp1_valid", 64'(if_id_valid), 64'd1);
      run("seq1");
      check("tp1_second", IF_ID, {32'h1, 32'h101});
      run("seq2");
      run("seq3");
      check("tp2_pre", IF_ID, {32'h3, 32'h103});

      // Stall for three cycles at pc=4; redirect wins over a held stall.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, '0, "stall");
      check("tp2_hold_pc", 64'(pc), 64'h4);
      check("tp2_hold_ifid", IF_ID, {32'h3, 32'h103});
      run("unstall");
      check("tp2_after", IF_ID, {32'h4, 32'h104});
      step(1'b1, 1'b1, 1'b1, 32'h20, 1'b0, '0, '0, "redir_stall");
      check("tp3_bubble", 64'(if_id_valid), 64'd0);
      check("tp3_pc", 64'(pc), 64'h20);
      run("redir_fetch");
      check("tp3_target", IF_ID, {32'h20, 32'hDEAD});

      // Walk off the end of memory.
      step(1'b1, 1'b0, 1'b1, 32'd126, 1'b0, '0, '0, "redir126");
      run("f126");
      run("f127");
      check("tp4_nofault", 64'(fetch_fault), 64'd0);
      run("f128");
      check("tp4_nop", IF_ID, {32'd128, NOP});
      check("tp4_fault", 64'(fetch_fault), 64'd1);
      run("f129");

      // Same-cycle write and fetch of address 5 returns the old word.
      step(1'b1, 1'b0, 1'b1, 32'd5, 1'b0, '0, '0, "redir5");
      step(1'b1, 1'b0, 1'b0, '0, 1'b1, 7'd5, 32'hBEEF, "wr_fetch5");
      check("tp5_old", IF_ID, {32'h5, 32'h105});
      step(1'b1, 1'b0, 1'b1, 32'd5, 1'b0, '0, '0, "redir5b");
      run("fetch5_new");
      check("tp5_new", IF_ID, {32'h5, 32'hBEEF});

      // PC wraps modulo 2^PC_W.
      step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, '0, '0, "redir_top");
      run("fetch_top");
      check("wrap_ifid", IF_ID, {32'hFFFF_FFFF, NOP});
      check("wrap_pc", 64'(pc), 64'h0);

      // Back-to-back redirects: last one wins, valid stays low.
      step(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, '0, '0, "b2b_a");
      step(1'b1, 1'b0, 1'b1, 32'h7, 1'b0, '0, '0, "b2b_b");
      check("b2b_valid", 64'(if_id_valid), 64'd0);
      run("b2b_fetch7");
      check("b2b_ifid", IF_ID, {32'h7, 32'h107});
      run("fetch8");
      check("tp6_pre_pc", 64'(pc), 64'h9);

      // Reset mid-run clears the pipeline and the sticky fault.
      step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, "mid_reset");
      check("tp6_pc", 64'(pc), 64'(RST_PC));
      check("tp6_fault", 64'(fetch_fault), 64'd0);
      check("tp6_ifid", IF_ID, 64'h0);
      run("post_reset");
      check("tp6_first", IF_ID, {32'(RST_PC), 32'h100});

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
